serial_link_master: RTL and testbench

- Host-side driver for the CPU top's bit-serial board link (datainbit / clk_data / data_sync_en / dataoutbit).
- Each frame:
  - serialises four 32-bit words towards the CPU side (instruction, load data, ...);
  - deserialises the four 32-bit words the CPU side returns (PC, memory address, store data).
- Sits directly upstream of the CPU top. Generates the link clock and sync strobe from one system clock.

---
 rtl/serial_link_master_if.sv | 28 ++
 rtl/serial_link_master.sv | 210 +++++++++++++++++++++
 tb/tb_serial_link_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_link_master_if.sv
// Host-side handshake and data bus of serial_link_master.
// master: the host that requests frames; slave: the link driver itself.
interface serial_link_master_if;
   logic         start;
   logic         loop_en;
   logic [127:0] tx_data;
   logic         busy;
   logic         done;
   logic [127:0] rx_data;

   modport master (
      output start,
      output loop_en,
      output tx_data,
      input  busy,
      input  done,
      input  rx_data
   );

   modport slave (
      input  start,
      input  loop_en,
      input  tx_data,
      output busy,
      output done,
      output rx_data
   );
endinterface

// File: rtl/serial_link_master.sv
// serial_link_master: host-side driver for the bit-serial CPU board link.
// Derives clk_data and the data_sync_en strobe from clk_sys. Every frame
// shifts four 32-bit words out on datainbit (LSB first) and collects the
// four words the CPU side returns on dataoutbit. Each slot is 32 shift
// bit-periods followed by one sync bit-period.
module serial_link_master #(
   parameter int unsigned CLK_DIV = 4   // clk_sys cycles per clk_data half-period, 1..255
) (
   input  logic                clk_sys,
   input  logic                sys_reset_n,
   serial_link_master_if.slave host,
   output logic                clk_data,
   output logic                datainbit,
   output logic                data_sync_en,
   input  logic                dataoutbit
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2
   } state_t;

   localparam logic [7:0] PHASE_LAST   = 8'(CLK_DIV - 1);
   localparam logic [5:0] LAST_SHIFT   = 6'd31;
   localparam logic [5:0] SYNC_BIT_IDX = 6'd32;
   localparam logic [1:0] LAST_SLOT    = 2'd3;

   state_t       state_reg, state_next;
   logic [7:0]   phase_cnt_reg, phase_cnt_next;
   logic [5:0]   bit_cnt_reg, bit_cnt_next;
   logic [1:0]   slot_cnt_reg, slot_cnt_next;
   logic [127:0] tx_buf_reg, tx_buf_next;
   logic [31:0]  rx_shift_reg, rx_shift_next;
   logic         clk_data_reg, clk_data_next;
   logic         datainbit_reg, datainbit_next;
   logic         sync_reg, sync_next;
   logic         busy_reg, busy_next;
   logic         done_reg, done_next;

   logic         phase_last;
   logic         sync_period;
   logic         slot_commit;
   logic         frame_end;
   logic         load_frame;
   logic [127:0] rx_data_all;

   // Phase/bit/slot boundary decode shared by the FSM and the rx word commit.
   always_comb begin
      phase_last  = (phase_cnt_reg == PHASE_LAST);
      sync_period = (bit_cnt_reg == SYNC_BIT_IDX);
      slot_commit = (state_reg == ST_HIGH) && phase_last && sync_period;
      frame_end   = slot_commit && (slot_cnt_reg == LAST_SLOT);
   end

   // Next-state logic: phase timing, bit/slot stepping, tx shifting and rx sampling.
   always_comb begin
      state_next     = state_reg;
      phase_cnt_next = phase_cnt_reg;
      bit_cnt_next   = bit_cnt_reg;
      slot_cnt_next  = slot_cnt_reg;
      tx_buf_next    = tx_buf_reg;
      rx_shift_next  = rx_shift_reg;
      datainbit_next = datainbit_reg;
      sync_next      = sync_reg;
      done_next      = 1'b0;
      load_frame     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            datainbit_next = 1'b0;
            sync_next      = 1'b0;
            if (host.start) begin
               load_frame = 1'b1;
            end
         end

         ST_LOW: begin
            if (phase_last) begin
               phase_cnt_next = '0;
               state_next     = ST_HIGH;
               // The CPU side holds its bit for the whole LOW phase; take it
               // at the last moment before the rising edge of clk_data.
               if (!sync_period) begin
                  rx_shift_next = {dataoutbit, rx_shift_reg[31:1]};
               end
            end else begin
               phase_cnt_next = phase_cnt_reg + 8'd1;
            end
         end

         ST_HIGH: begin
            if (phase_last) begin
               phase_cnt_next = '0;
               if (frame_end) begin
                  done_next = 1'b1;
                  if (host.loop_en) begin
                     load_frame = 1'b1;
                  end else begin
                     state_next     = ST_IDLE;
                     datainbit_next = 1'b0;
                     sync_next      = 1'b0;
                  end
               end else begin
                  state_next = ST_LOW;
                  if (sync_period) begin
                     // Sync done: bit 0 of the next slot's word.
                     bit_cnt_next   = '0;
                     slot_cnt_next  = slot_cnt_reg + 2'd1;
                     datainbit_next = tx_buf_reg[0];
                     tx_buf_next    = tx_buf_reg >> 1;
                     sync_next      = 1'b0;
                  end else if (bit_cnt_reg == LAST_SHIFT) begin
                     bit_cnt_next   = SYNC_BIT_IDX;
                     datainbit_next = 1'b0;
                     sync_next      = 1'b1;
                  end else begin
                     bit_cnt_next   = bit_cnt_reg + 6'd1;
                     datainbit_next = tx_buf_reg[0];
                     tx_buf_next    = tx_buf_reg >> 1;
                  end
               end
            end else begin
               phase_cnt_next = phase_cnt_reg + 8'd1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Frame (re)start: snapshot the host words and present bit 0 of word 0
      // right away, so the first LOW phase already carries valid data.
      if (load_frame) begin
         state_next     = ST_LOW;
         phase_cnt_next = '0;
         bit_cnt_next   = '0;
         slot_cnt_next  = '0;
         tx_buf_next    = host.tx_data >> 1;
         datainbit_next = host.tx_data[0];
         sync_next      = 1'b0;
      end

      // Link clock and busy follow the state being entered, so both come
      // straight from flops with no decode glitches.
      clk_data_next = (state_next == ST_HIGH);
      busy_next     = (state_next != ST_IDLE);
   end

   // State, counters, shift buffers and registered link/handshake outputs.
   always_ff @(posedge clk_sys or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         state_reg     <= ST_IDLE;
         phase_cnt_reg <= '0;
         bit_cnt_reg   <= '0;
         slot_cnt_reg  <= '0;
         tx_buf_reg    <= '0;
         rx_shift_reg  <= '0;
         clk_data_reg  <= 1'b0;
         datainbit_reg <= 1'b0;
         sync_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         phase_cnt_reg <= phase_cnt_next;
         bit_cnt_reg   <= bit_cnt_next;
         slot_cnt_reg  <= slot_cnt_next;
         tx_buf_reg    <= tx_buf_next;
         rx_shift_reg  <= rx_shift_next;
         clk_data_reg  <= clk_data_next;
         datainbit_reg <= datainbit_next;
         sync_reg      <= sync_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   // One holding register per received word; only the slot whose sync
   // period is closing updates, the others keep their last value.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rx_word
         logic [31:0] word_reg;
         logic        word_we;

         assign word_we = slot_commit && (slot_cnt_reg == 2'(gi));

         // Commit the assembled word for this slot at the end of its sync period.
         always_ff @(posedge clk_sys or negedge sys_reset_n) begin
            if (!sys_reset_n) begin
               word_reg <= '0;
            end else if (word_we) begin
               word_reg <= rx_shift_reg;
            end
         end

         assign rx_data_all[32*gi +: 32] = word_reg;
      end
   endgenerate

   assign clk_data     = clk_data_reg;
   assign datainbit    = datainbit_reg;
   assign data_sync_en = sync_reg;
   assign host.busy    = busy_reg;
   assign host.done    = done_reg;
   assign host.rx_data = rx_data_all;

endmodule

// File: tb/tb_serial_link_master.sv
// Directed bench for serial_link_master: a CLK_DIV=2 instance wired to a
// behavioural CPU-side link model, plus a CLK_DIV=1 instance with start
// held high. One line is printed per completed frame.
module tb_serial_link_master;

   logic clk_sys = 1'b0;
   logic sys_reset_n;
   logic rst1_n;

   always #5 clk_sys = ~clk_sys;

   serial_link_master_if bus ();
   serial_link_master_if bus1 ();

   logic clk_data, datainbit, data_sync_en, dataoutbit;
   logic clk_data1, datainbit1, data_sync_en1, dataoutbit1;

   serial_link_master #(.CLK_DIV(2)) dut (
      .clk_sys      (clk_sys),
      .sys_reset_n  (sys_reset_n),
      .host         (bus),
      .clk_data     (clk_data),
      .datainbit    (datainbit),
      .data_sync_en (data_sync_en),
      .dataoutbit   (dataoutbit)
   );

   serial_link_master #(.CLK_DIV(1)) dut1 (
      .clk_sys      (clk_sys),
      .sys_reset_n  (rst1_n),
      .host         (bus1),
      .clk_data     (clk_data1),
      .datainbit    (datainbit1),
      .data_sync_en (data_sync_en1),
      .dataoutbit   (dataoutbit1)
   );

   assign dataoutbit1 = 1'b0;

   // ---------------- CPU-side link model ----------------
   logic [31:0] m_in_shift;
   logic [31:0] m_out_shift;
   logic [31:0] m_in_slot [4];
   logic [31:0] m_out_word [4];
   logic [1:0]  m_slot;
   logic [1:0]  m_next_slot;

   assign m_next_slot = m_slot + 2'd1;
   assign dataoutbit  = m_out_shift[0];

   // Shift on each link rising edge; at sync, latch into input slot k+1 and
   // load output slot k+1 for the next slot's transfer.
   always @(posedge clk_data or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         m_in_shift  <= '0;
         m_out_shift <= '0;
         m_slot      <= '0;
         for (int k = 0; k < 4; k++) m_in_slot[k] <= '0;
      end else if (data_sync_en) begin
         m_in_slot[m_next_slot] <= m_in_shift;
         m_out_shift            <= m_out_word[m_next_slot];
         m_slot                 <= m_next_slot;
      end else begin
         m_in_shift  <= {datainbit, m_in_shift[31:1]};
         m_out_shift <= {1'b0, m_out_shift[31:1]};
      end
   end

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- frame monitor ----------------
   logic [127:0] tx_a, tx_b;
   int           mon_rise, mon_sync_rise, mon_done_n, mon_busy_low;
   logic         mon_busy_first;
   int           mon_done_at [4];
   logic         mon_busy_at_done [4];
   logic [127:0] mon_rx_at_done [4];
   logic [127:0] mon_in_at_done [4];
   int           mon_rx_chg [4];

   task automatic start_frame();
      bus.start = 1'b1;
      @(posedge clk_sys);
      #1 bus.start = 1'b0;
   endtask

   // Watch dut for up to 'limit' cycles after the accepting edge (cycle n=1
   // is the first one after it) until 'frames' done pulses have been seen.
   task automatic monitor(input int frames, input int limit, input int tx_chg_at, input int loop_off_at);
      logic         prev_clk;
      logic [127:0] prev_rx;
      prev_clk       = clk_data;
      prev_rx        = bus.rx_data;
      mon_rise       = 0;
      mon_sync_rise  = 0;
      mon_done_n     = 0;
      mon_busy_low   = 0;
      mon_busy_first = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mon_rx_chg[k]  = -1;
         mon_done_at[k] = -1;
      end
      for (int n = 1; n <= limit && mon_done_n < frames; n++) begin
         @(negedge clk_sys);
         if (n == 1) mon_busy_first = bus.busy;
         if (n == tx_chg_at) bus.tx_data = tx_b;
         if (n == loop_off_at) bus.loop_en = 1'b0;
         if (clk_data && !prev_clk) begin
            mon_rise++;
            if (data_sync_en) mon_sync_rise++;
         end
         prev_clk = clk_data;
         for (int k = 0; k < 4; k++) begin
            if (mon_rx_chg[k] < 0 && bus.rx_data[32*k +: 32] !== prev_rx[32*k +: 32]) mon_rx_chg[k] = n;
         end
         prev_rx = bus.rx_data;
         if (!bus.busy && !bus.done) mon_busy_low++;
         if (bus.done && mon_done_n < 4) begin
            mon_done_at[mon_done_n]      = n;
            mon_busy_at_done[mon_done_n] = bus.busy;
            mon_rx_at_done[mon_done_n]   = bus.rx_data;
            mon_in_at_done[mon_done_n]   = {m_in_slot[3], m_in_slot[2], m_in_slot[1], m_in_slot[0]};
            $display("frame %0d done at cycle %0d busy=%0b rx_data=%h", mon_done_n, n, bus.busy, bus.rx_data);
            mon_done_n++;
         end
      end
   endtask

   // ---------------- fast instance results ----------------
   int   r1_first, r1_second, r1_rise, r1_sync, r1_din_hi, r1_busy_low, r1_done_n;
   int   r1_done_at [2];
   logic r1_busy_at_done;
   logic r1_prev;
   logic seen_done;

   initial begin
      #200000;
      $display("FAIL watchdog sim_time=%0t limit=200000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      sys_reset_n  = 1'b0;
      rst1_n       = 1'b0;
      bus.start    = 1'b1;
      bus.loop_en  = 1'b0;
      bus.tx_data  = '0;
      bus1.start   = 1'b0;
      bus1.loop_en = 1'b0;
      bus1.tx_data = '0;
      m_out_word[0] = 32'hA5A5_A5A5;
      m_out_word[1] = 32'h0000_0000;
      m_out_word[2] = 32'hFFFF_FFFF;
      m_out_word[3] = 32'h0000_BEEF;
      tx_a = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      tx_b = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};

      // Reset held with start=1: everything quiet.
      repeat (3) begin
         @(negedge clk_sys);
         check_eq("rst_outs", {clk_data, datainbit, data_sync_en, bus.busy, bus.done}, 5'b0);
      end
      check_eq("rst_rx", bus.rx_data, 128'h0);

      // Release, start a frame and abort it at cycle 100.
      bus.start   = 1'b0;
      sys_reset_n = 1'b1;
      @(negedge clk_sys);
      start_frame();
      for (int n = 1; n <= 100; n++) @(negedge clk_sys);
      check_eq("pre_abort_clk_busy", {clk_data, bus.busy}, 2'b11);
      #2 sys_reset_n = 1'b0;
      #1;
      check_eq("abort_async_clk_busy", {clk_data, bus.busy}, 2'b00);
      seen_done = 1'b0;
      repeat (4) begin
         @(negedge clk_sys);
         seen_done |= bus.done;
      end
      sys_reset_n = 1'b1;
      repeat (10) begin
         @(negedge clk_sys);
         seen_done |= bus.done;
      end
      check_eq("abort_no_done", seen_done, 1'b0);
      check_eq("abort_idle_busy", bus.busy, 1'b0);
      $display("abort test complete");

      // Single frame, CLK_DIV=2.
      bus.tx_data = {32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_0001};
      bus.loop_en = 1'b0;
      start_frame();
      monitor(1, 1000, 0, 0);
      check_eq("single_done_cnt", mon_done_n, 1);
      check_eq("single_busy_rise", mon_busy_first, 1'b1);
      check_eq("single_done_cycle", mon_done_at[0], 529);
      check_eq("single_busy_at_done", mon_busy_at_done[0], 1'b0);
      check_eq("single_clk_rises", mon_rise, 132);
      check_eq("single_sync_rises", mon_sync_rise, 4);
      check_eq("single_busy_gaps", mon_busy_low, 0);
      check_eq("single_cpu_in_slots", mon_in_at_done[0],
               {32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678});
      check_eq("single_rx_data", mon_rx_at_done[0],
               {32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
      check_eq("single_rx0_chg", mon_rx_chg[0], -1);
      check_eq("single_rx1_chg", mon_rx_chg[1], -1);
      check_eq("single_rx2_chg", mon_rx_chg[2], 397);
      check_eq("single_rx3_chg", mon_rx_chg[3], 529);
      @(negedge clk_sys);
      check_eq("done_width", bus.done, 1'b0);

      // Three looped frames, tx_data changed during frame 1.
      bus.tx_data = tx_a;
      bus.loop_en = 1'b1;
      start_frame();
      monitor(3, 2000, 200, 1100);
      check_eq("loop_done_cnt", mon_done_n, 3);
      check_eq("loop_done0", mon_done_at[0], 529);
      check_eq("loop_done1", mon_done_at[1], 1057);
      check_eq("loop_done2", mon_done_at[2], 1585);
      check_eq("loop_busy_at_done", {mon_busy_at_done[0], mon_busy_at_done[1], mon_busy_at_done[2]}, 3'b110);
      check_eq("loop_busy_gaps", mon_busy_low, 0);
      check_eq("loop_clk_rises", mon_rise, 396);
      check_eq("loop_sync_rises", mon_sync_rise, 12);
      check_eq("loop_f1_in_slots", mon_in_at_done[0],
               {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h4444_4444});
      check_eq("loop_f2_in_slots", mon_in_at_done[1],
               {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h8888_8888});
      check_eq("loop_f1_rx_data", mon_rx_at_done[0],
               {32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5});
      check_eq("loop_rx0_chg", mon_rx_chg[0], 133);

      // Reset clears the received words asynchronously.
      #2 sys_reset_n = 1'b0;
      #1;
      check_eq("rst_rx_clear", bus.rx_data, 128'h0);
      @(negedge clk_sys);
      sys_reset_n = 1'b1;

      // CLK_DIV=1 instance with start held high, loop_en=0.
      bus1.start = 1'b1;
      rst1_n     = 1'b1;
      @(posedge clk_sys);
      r1_first = -1; r1_second = -1; r1_rise = 0; r1_sync = 0;
      r1_din_hi = 0; r1_busy_low = 0; r1_done_n = 0;
      r1_done_at[0] = -1; r1_done_at[1] = -1;
      r1_busy_at_done = 1'b1;
      r1_prev = clk_data1;
      for (int n = 1; n <= 530; n++) begin
         @(negedge clk_sys);
         if (clk_data1 && !r1_prev) begin
            if (r1_first < 0) r1_first = n;
            else if (r1_second < 0) r1_second = n;
            if (r1_done_n == 0) r1_rise++;
            if (data_sync_en1) r1_sync++;
         end
         r1_prev = clk_data1;
         if (datainbit1) r1_din_hi++;
         if (n < 530 && !bus1.busy) r1_busy_low++;
         if (bus1.done) begin
            if (r1_done_n == 0) r1_busy_at_done = bus1.busy;
            if (r1_done_n < 2) r1_done_at[r1_done_n] = n;
            $display("fast frame %0d done at cycle %0d busy=%0b", r1_done_n, n, bus1.busy);
            r1_done_n++;
         end
      end
      check_eq("fast_first_rise", r1_first, 2);
      check_eq("fast_clk_period", r1_second - r1_first, 2);
      check_eq("fast_rises_frame0", r1_rise, 132);
      check_eq("fast_sync_rises", r1_sync, 8);
      check_eq("fast_done0", r1_done_at[0], 265);
      check_eq("fast_done1", r1_done_at[1], 530);
      check_eq("fast_busy_at_done0", r1_busy_at_done, 1'b0);
      check_eq("fast_busy_low_cycles", r1_busy_low, 1);
      check_eq("fast_din_zero", r1_din_hi, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
